// File: rtl/r_type_sequencer.sv
// rtl/r_type_sequencer.sv - multicycle sequencer for one RISC-V R-type instruction at a time
// Owns register-file read strobes, ALU operands and write-back for OP / OP-32 encodings.
module r_type_sequencer #(
    parameter int WORDSIZE = 64,
    parameter int SIZE     = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [SIZE-1:0]     instruction,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    output logic                rs_read_en,
    input  logic [WORDSIZE-1:0] rs1_data,
    input  logic [WORDSIZE-1:0] rs2_data,
    output logic [WORDSIZE-1:0] alu_a,
    output logic [WORDSIZE-1:0] alu_b,
    output logic [3:0]          alu_op,
    output logic                alu_word,
    input  logic [WORDSIZE-1:0] alu_result,
    output logic [4:0]          rd_addr,
    output logic [WORDSIZE-1:0] rd_data,
    output logic                rd_we,
    output logic                done,
    output logic                illegal,
    output logic [31:0]         retired_count
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OP32  = 7'b0111011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DECODE  = 3'd1,
        S_READ    = 3'd2,
        S_EXEC    = 3'd3,
        S_WB      = 3'd4,
        S_ILLEGAL = 3'd5
    } state_t;

    state_t          state;
    logic [SIZE-1:0] instr_q;

    logic [6:0] funct7;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       sub_sra;
    logic       f3_ok;
    logic       f7_ok;
    logic       dec_legal;
    logic       dec_word;
    logic [3:0] dec_op;

    assign funct7 = instr_q[31:25];
    assign funct3 = instr_q[14:12];
    assign opcode = instr_q[6:0];

    always_comb begin
        dec_word  = (opcode == OPC_OP32);
        sub_sra   = (funct3 == 3'b000) || (funct3 == 3'b101);
        // OP-32 only has ADD/SUB, SLL, SRL/SRA
        f3_ok     = (opcode == OPC_OP) || sub_sra || (funct3 == 3'b001);
        f7_ok     = (funct7 == F7_BASE) || ((funct7 == F7_ALT) && sub_sra);
        dec_legal = ((opcode == OPC_OP) || (opcode == OPC_OP32)) && f3_ok && f7_ok;
        dec_op    = ALU_ADD;
        case (funct3)
            3'b000:  dec_op = funct7[5] ? ALU_SUB : ALU_ADD;
            3'b001:  dec_op = ALU_SLL;
            3'b010:  dec_op = ALU_SLT;
            3'b011:  dec_op = ALU_SLTU;
            3'b100:  dec_op = ALU_XOR;
            3'b101:  dec_op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  dec_op = ALU_OR;
            default: dec_op = ALU_AND;
        endcase
    end

    // Write-back data comes straight from the combinational ALU during WB
    assign rd_data = (state == S_WB) ? alu_result : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            instr_q       <= '0;
            instr_ready   <= 1'b1;
            rs1_addr      <= '0;
            rs2_addr      <= '0;
            rd_addr       <= '0;
            rs_read_en    <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= '0;
            alu_word      <= 1'b0;
            rd_we         <= 1'b0;
            done          <= 1'b0;
            illegal       <= 1'b0;
            retired_count <= '0;
        end else begin
            rs_read_en <= 1'b0;
            rd_we      <= 1'b0;
            done       <= 1'b0;
            illegal    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q     <= instruction;
                        instr_ready <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    rs1_addr <= instr_q[19:15];
                    rs2_addr <= instr_q[24:20];
                    rd_addr  <= instr_q[11:7];
                    alu_op   <= dec_op;
                    alu_word <= dec_word;
                    if (dec_legal) begin
                        rs_read_en <= 1'b1;
                        state      <= S_READ;
                    end else begin
                        done    <= 1'b1;
                        illegal <= 1'b1;
                        state   <= S_ILLEGAL;
                    end
                end
                S_READ: begin
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    alu_a         <= rs1_data;
                    alu_b         <= rs2_data;
                    done          <= 1'b1;
                    rd_we         <= (rd_addr != 5'd0);
                    retired_count <= retired_count + 32'd1;
                    state         <= S_WB;
                end
                S_WB, S_ILLEGAL: begin
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_r_type_sequencer.sv
// tb/tb_r_type_sequencer.sv - scoreboard bench for r_type_sequencer
// Random R-type / illegal instructions against a behavioural decode, register file and ALU model.
module tb_r_type_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        rs_read_en;
    logic [63:0] rs1_data, rs2_data, alu_a, alu_b, alu_result, rd_data;
    logic [3:0]  alu_op;
    logic        alu_word, rd_we, done, illegal;
    logic [31:0] retired_count;

    r_type_sequencer #(.WORDSIZE(64), .SIZE(32)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs_read_en(rs_read_en), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_word(alu_word),
        .alu_result(alu_result), .rd_addr(rd_addr), .rd_data(rd_data), .rd_we(rd_we),
        .done(done), .illegal(illegal), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          hs;
        bit          legal;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        bit          w;
        logic [63:0] a, b, res;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          quiet = 1'b0;
    logic [63:0] rf [32];
    logic [31:0] exp_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                               input logic [3:0] op, input bit w);
        logic signed [63:0] sa;
        logic signed [31:0] sa32;
        logic [31:0]        r32;
        logic [63:0]        r;
        sa = a;
        sa32 = a[31:0];
        r = 64'd0;
        r32 = 32'd0;
        if (!w) begin
            case (op)
                4'd0: r = a + b;
                4'd1: r = a - b;
                4'd2: r = a << b[5:0];
                4'd3: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                4'd4: r = (a < b) ? 64'd1 : 64'd0;
                4'd5: r = a ^ b;
                4'd6: r = a >> b[5:0];
                4'd7: r = sa >>> b[5:0];
                4'd8: r = a | b;
                4'd9: r = a & b;
                default: r = 64'd0;
            endcase
        end else begin
            case (op)
                4'd0: r32 = a[31:0] + b[31:0];
                4'd1: r32 = a[31:0] - b[31:0];
                4'd2: r32 = a[31:0] << b[4:0];
                4'd6: r32 = a[31:0] >> b[4:0];
                4'd7: r32 = sa32 >>> b[4:0];
                default: r32 = 32'd0;
            endcase
            r = {{32{r32[31]}}, r32};
        end
        return r;
    endfunction

    always_comb alu_result = alu_model(alu_a, alu_b, alu_op, alu_word);

    // Register file responder: data one cycle after the strobe, noise otherwise
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rs_read_en) begin
            rs1_data <= rf[rs1_addr];
            rs2_data <= rf[rs2_addr];
        end else begin
            rs1_data <= {$urandom, $urandom};
            rs2_data <= {$urandom, $urandom};
        end
    end

    function automatic exp_t model(input logic [31:0] ins, input int hs);
        exp_t e;
        int   tbl[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [6:0] opc, f7;
        logic [2:0] f3;
        bit op64, op32, alt;
        opc = ins[6:0];
        f7 = ins[31:25];
        f3 = ins[14:12];
        op64 = (opc == 7'h33);
        op32 = (opc == 7'h3b);
        alt = (f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5);
        e.hs = hs;
        e.legal = (op64 || op32) && (f7 == 7'h00 || alt)
                  && (op64 || f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5);
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd = ins[11:7];
        e.w = op32;
        e.op = alt ? ((f3 == 3'd0) ? 4'd1 : 4'd7) : 4'(tbl[f3]);
        e.a = rf[e.rs1];
        e.b = rf[e.rs2];
        e.res = alu_model(e.a, e.b, e.op, e.w);
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [2:0]  f3;
        int          k;
        ins = $urandom;
        f3 = 3'($urandom_range(0, 7));
        k = $urandom_range(0, 7);
        case (k)
            0, 1: ins = {7'h00, ins[24:15], f3, ins[11:7], 7'h33};
            2:    ins = {7'h20, ins[24:15], ($urandom_range(0, 1) != 0) ? 3'd0 : 3'd5, ins[11:7], 7'h33};
            3:    ins = {($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00, ins[24:15],
                         ($urandom_range(0, 2) == 0) ? 3'd0 : (($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5),
                         ins[11:7], 7'h3b};
            4:    ins = {7'h20, ins[24:15], f3, ins[11:7], 7'h33};
            5:    ins = {7'h01, ins[24:15], f3, ins[11:7], ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h3b};
            6:    ins = {7'h00, ins[24:15], f3, ins[11:7], 7'h3b};
            default: ;
        endcase
        if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
        return ins;
    endfunction

    int  prev_hs = -100;
    bit  prev_legal = 1'b0;

    task automatic issue(input logic [31:0] ins, input bit b2b);
        int   n;
        exp_t e;
        n = 0;
        instr_valid = 1'b1;
        instruction = $urandom;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            instruction = $urandom;
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            total++; bad++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        instruction = ins;
        e = model(ins, cyc);
        if (b2b) chk("b2b_accept_cycle", 64'(e.hs), 64'(prev_hs + (prev_legal ? 5 : 3)));
        prev_hs = e.hs;
        prev_legal = e.legal;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    bit  p_done = 0, p_we = 0, p_rd = 0, p_ill = 0, cnt_pend = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset && !quiet) begin
            if (cnt_pend) begin
                chk("retired_count", 64'(retired_count), 64'(exp_cnt));
                cnt_pend = 0;
            end
            if (done) chk("done_one_cycle", 64'(p_done), 0);
            if (rd_we) chk("rd_we_one_cycle", 64'(p_we), 0);
            if (rs_read_en) chk("rs_read_en_one_cycle", 64'(p_rd), 0);
            if (illegal) chk("illegal_one_cycle", 64'(p_ill), 0);
            if (illegal && !done) chk("illegal_without_done", 64'(illegal), 0);
            if (rs_read_en) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_read actual=1 required=0");
                end else begin
                    e = q[0];
                    chk("read_legal", 64'(1), 64'(e.legal));
                    chk("read_cycle", 64'(cyc), 64'(e.hs + 2));
                    chk("rs1_addr", 64'(rs1_addr), 64'(e.rs1));
                    chk("rs2_addr", 64'(rs2_addr), 64'(e.rs2));
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(e.hs + (e.legal ? 4 : 2)));
                    chk("illegal", 64'(illegal), 64'(!e.legal));
                    if (e.legal) begin
                        chk("rd_we", 64'(rd_we), 64'(e.rd != 5'd0));
                        chk("rd_addr", 64'(rd_addr), 64'(e.rd));
                        chk("alu_op", 64'(alu_op), 64'(e.op));
                        chk("alu_word", 64'(alu_word), 64'(e.w));
                        chk("alu_a", alu_a, e.a);
                        chk("alu_b", alu_b, e.b);
                        chk("rd_data", rd_data, e.res);
                        exp_cnt = exp_cnt + 32'd1;
                    end else begin
                        chk("illegal_rd_we", 64'(rd_we), 0);
                    end
                    cnt_pend = 1;
                end
            end else if (rd_we) begin
                total++; bad++;
                $display("FAIL rd_we_without_done actual=1 required=0");
            end
        end
        if (quiet && !reset) begin
            chk("quiet_rd_we", 64'(rd_we), 0);
            chk("quiet_done", 64'(done), 0);
        end
        p_done = done; p_we = rd_we; p_rd = rs_read_en; p_ill = illegal;
    end

    initial begin
        #2000000;
        total++; bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] directed [6] = '{32'h002081B3, 32'h407302B3, 32'h4012523B,
                                  32'h00208033, 32'h022081B3, 32'h00208003};

    initial begin
        int hs0, n;
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
        rf[0] = 64'd0; rf[1] = 64'd5; rf[2] = 64'd7; rf[6] = 64'd3; rf[7] = 64'd10;
        reset = 1'b1;
        instr_valid = 1'b0;
        instruction = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", 64'(instr_ready), 1);
        chk("reset_done", 64'(done), 0);
        chk("reset_rd_we", 64'(rd_we), 0);
        chk("reset_read_en", 64'(rs_read_en), 0);
        chk("reset_illegal", 64'(illegal), 0);
        chk("reset_count", 64'(retired_count), 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_rd_addr", 64'(rd_addr), 0);
        @(posedge clk); #1;

        // Reset during EXEC of an ADD must drop it silently
        quiet = 1'b1;
        instr_valid = 1'b1;
        instruction = 32'h002081B3;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin @(negedge clk); n++; end
        hs0 = cyc;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        while (cyc < hs0 + 3 && n < 40) begin @(posedge clk); #1; n++; end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 64'(instr_ready), 1);
        chk("rst_mid_count", 64'(retired_count), 0);
        repeat (4) @(negedge clk);
        quiet = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            instr_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1 issue(directed[i], 1'b0);
        end
        for (int i = 0; i < 300; i++) begin
            int gap;
            gap = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            if (gap > 0) begin
                instr_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            issue(rand_instr(), gap == 0 && i > 0);
        end
        instr_valid = 1'b0;
        n = 0;
        while (q.size() > 0 && n < 50) begin @(posedge clk); n++; end
        repeat (2) @(posedge clk);
        chk("drain_queue", 64'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/r_type_sequencer.md
# r_type_sequencer

Multicycle controller that sequences execution of one RISC-V R-type instruction at a time: accepts a raw 32-bit instruction over a valid/ready handshake, splits it into funct7/rs2/rs1/funct3/rd/opcode, checks legality, drives the register-file read ports, feeds the ALU, and commits the result to rd. It sits between the fetch/issue stage and the shared register file/ALU datapath and owns every control strobe for them during an R-type operation.

## Interface
- WORDSIZE, 64, datapath width (register and ALU operand width)
- SIZE, 32, instruction width
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- instr_valid  in  1  issue stage offers an instruction
- instr_ready  out  1  sequencer can accept (high only in IDLE)
- instruction  in  SIZE  raw instruction, sampled on handshake
- rs1_addr, rs2_addr  out  5 each  register-file read addresses
- rs_read_en  out  1  register-file read strobe; data valid the following cycle
- rs1_data, rs2_data  in  WORDSIZE  register-file read data
- alu_a, alu_b  out  WORDSIZE  registered ALU operands
- alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND
- alu_word  out  1  32-bit (W) operation; ALU sign-extends its 32-bit result
- alu_result  in  WORDSIZE  combinational ALU result
- rd_addr  out  5  write-back address
- rd_data  out  WORDSIZE  write-back data
- rd_we  out  1  write-back strobe, one cycle
- done  out  1  one-cycle pulse at end of every accepted instruction
- illegal  out  1  qualifies done: instruction rejected
- retired_count  out  32  count of legally completed instructions

## Operation
- States: IDLE, DECODE, READ, EXEC, WB, ILLEGAL.
- IDLE: instr_ready=1; on instr_valid & instr_ready latch instruction -> DECODE.
- DECODE: fields from latched word (funct7=[31:25], rs2=[24:20], rs1=[19:15], funct3=[14:12], rd=[11:7], opcode=[6:0]); register rs1_addr, rs2_addr, rd_addr, alu_op, alu_word. Legal -> READ, else -> ILLEGAL.
- Legality: opcode 0110011 (OP): funct7 0000000 any funct3; funct7 0100000 only with funct3 000 (SUB) or 101 (SRA). Opcode 0111011 (OP-32): funct3 in {000,001,101} with the same funct7 rules, alu_word=1. Any other opcode/funct7 (including 0000001, M-extension) is illegal.
- READ: rs_read_en=1 for exactly one cycle -> EXEC.
- EXEC: capture rs1_data->alu_a, rs2_data->alu_b at end of cycle -> WB.
- WB: rd_data=alu_result, rd_we=1 unless rd_addr==0, done=1, retired_count+1 (incremented even when rd==0) -> IDLE.
- ILLEGAL: done=1, illegal=1, no rd_we, no read, counter unchanged -> IDLE.
- retired_count wraps 0xFFFFFFFF -> 0.
- Address/op outputs hold last decoded values until next DECODE.

## Timing
- Reset: state IDLE; every output 0 except instr_ready=1; retired_count=0.
- Handshake edge = cycle 0. DECODE c1, READ c2, EXEC c3, WB c4 (done, rd_we), instr_ready high again c5. Throughput: one instruction per 5 cycles.
- Illegal: DECODE c1, ILLEGAL c2 (done+illegal), ready c3.
- instr_valid while not ready is ignored; instruction is not sampled.
- Reset in any state: next edge IDLE, in-flight instruction dropped, no rd_we or done emitted in or after the reset cycle.
- done, rd_we, rs_read_en, illegal are never high for more than one consecutive cycle.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1_data=5, rs2_data=7 -> rs_read_en c2 with addrs 1/2, alu_op=0, rd_we c4 rd_addr=3 rd_data=alu_result, retired_count=1.
- SUB x5,x6,x7 (0x407302B3), rs1=3, rs2=10 -> alu_op=1, alu_a=3, alu_b=10 at c4, write to x5.
- SRAW x4,x4,x1 (0x4012523B) -> alu_op=7, alu_word=1, legal, done c4.
- ADD x0,x1,x2 (0x00208033) -> done c4, rd_we=0, retired_count still increments.
- MUL (0x022081B3) and opcode 0000011 -> illegal+done at c2, no rs_read_en, no rd_we, count unchanged, ready c3.
- Reset asserted at c3 of ADD -> IDLE next edge, rd_we never pulses, retired_count=0; back-to-back instr_valid held high -> second instruction accepted exactly at c5.
